// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the serial adder/subtractor:
//   state_t  - controller states (IDLE, RUN, DONE)
//   clog2    - ceiling log2, sizes the digit counter
//   full_add - one-bit full-adder cell, returns {carry_out, sum}
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
        return {co, s};
    endfunction

endpackage

// File: rtl/ser_digit_add.sv
// ---------------------------------------------------------------------------
// ser_digit_add
// BPC-bit ripple-carry adder built from the shared full-adder cell.
// Ports:
//   a, b   [BPC-1:0]  digit operands
//   cin               carry into bit 0
//   sum    [BPC-1:0]  digit sum
//   cout              carry out of the top bit
//   c_msb             carry into the top bit (for signed overflow)
// ---------------------------------------------------------------------------
module ser_digit_add
    import ser_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] a,
    input  logic [BPC-1:0] b,
    input  logic           cin,
    output logic [BPC-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [BPC:0] carry;

    // Ripple chain: carry[i] is the carry into bit i.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < BPC; i++) begin
            {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
        end
    end

    assign cout  = carry[BPC];
    assign c_msb = carry[BPC-1];

endmodule

// File: rtl/ser_addsub.sv
// ---------------------------------------------------------------------------
// ser_addsub
// Multi-cycle serial adder/subtractor. Operands are parallel-loaded on an
// accepted start, then BPC bits are added per clock, LSB first, with the
// carry held in a flop between digits. The full result, carry/borrow and
// signed overflow are held after completion.
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-low reset
//   start      request, sampled only in IDLE
//   sub        0 = a+b, 1 = a-b (captured with start)
//   a, b       [WIDTH-1:0] operands (captured with start)
//   busy       high while digits are being processed
//   done       one-cycle completion pulse
//   ser_sum    [BPC-1:0] current digit, zero when not valid
//   ser_valid  ser_sum valid this cycle
//   result     [WIDTH-1:0] full sum/difference
//   cout       carry out of MSB (for sub: 1 = no borrow)
//   ovf        two's-complement overflow
// ---------------------------------------------------------------------------
module ser_addsub
    import ser_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [BPC-1:0]   ser_sum,
    output logic             ser_valid,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NCYC = WIDTH / BPC;
    localparam int CW   = clog2(NCYC) + 1;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [BPC-1:0]   digit_sum;
    logic             digit_cout;
    logic             digit_cmsb;

    ser_digit_add #(
        .BPC (BPC)
    ) u_digit (
        .a     (op_a[BPC-1:0]),
        .b     (op_b[BPC-1:0]),
        .cin   (carry),
        .sum   (digit_sum),
        .cout  (digit_cout),
        .c_msb (digit_cmsb)
    );

    // Controller and datapath. Subtraction is a + ~b + 1: b is inverted at
    // load time and the carry flop is seeded with 1. Each digit enters the
    // result from the top so that after NCYC shifts the first digit sits at
    // the LSB. The shift is written with >> and << so BPC == WIDTH works too.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> BPC;
                    op_b   <= op_b >> BPC;
                    result <= (result >> BPC) | (WIDTH'(digit_sum) << (WIDTH - BPC));
                    carry  <= digit_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NCYC - 1)) begin
                        cout  <= digit_cout;
                        ovf   <= digit_cmsb ^ digit_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign ser_valid = (state == RUN);
    assign ser_sum   = ser_valid ? digit_sum : '0;

endmodule

// File: tb/tb_ser_addsub.sv
// ---------------------------------------------------------------------------
// tb_ser_addsub
// Two instances (BPC=1 and BPC=4, WIDTH=16) driven from shared operands with
// separate start lines. Expected results come from plain integer arithmetic
// and are queued per instance when a start is issued; a single monitor on
// the falling edge pops and compares serial digits and final results.
// ---------------------------------------------------------------------------
module tb_ser_addsub;

    localparam int W      = 16;
    localparam int BPC_A  = 1;
    localparam int BPC_B  = 4;
    localparam int NCYC_A = W / BPC_A;
    localparam int NCYC_B = W / BPC_B;

    if ((W % BPC_A) != 0 || (W % BPC_B) != 0) begin : g_bpc_check
        $error("[TB] BPC must divide WIDTH exactly");
    end

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        int          startCycle;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start0;
    logic        start1;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy0, done0, valid0, cout0, ovf0;
    logic [0:0]  sum0;
    logic [15:0] result0;
    logic        busy1, done1, valid1, cout1, ovf1;
    logic [3:0]  sum1;
    logic [15:0] result1;

    exp_t q0[$];
    exp_t q1[$];
    int   digIdx0;
    int   digIdx1;
    int   cycle;
    logic rstLast;
    int   checks;
    int   fails;

    ser_addsub #(.WIDTH(W), .BPC(BPC_A)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .sub(sub), .a(a), .b(b),
        .busy(busy0), .done(done0), .ser_sum(sum0), .ser_valid(valid0),
        .result(result0), .cout(cout0), .ovf(ovf0)
    );

    ser_addsub #(.WIDTH(W), .BPC(BPC_B)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub), .a(a), .b(b),
        .busy(busy1), .done(done1), .ser_sum(sum1), .ser_valid(valid1),
        .result(result1), .cout(cout1), .ovf(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle   = 0;
        rstLast = 1'b1;
    end

    always @(posedge clk) begin
        cycle   <= cycle + 1;
        rstLast <= reset;
    end

    // Reference arithmetic: modulo-2^16 add/sub, unsigned carry/no-borrow,
    // and signed overflow from operand/result signs.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input int sc);
        exp_t        r;
        longint      ux;
        longint      uy;
        longint      full;
        ux = longint'(x);
        uy = longint'(y);
        r.startCycle = sc;
        if (!s) begin
            full  = ux + uy;
            r.res = full[15:0];
            r.co  = (full >= 65536);
            r.ov  = (x[15] == y[15]) && (r.res[15] != x[15]);
        end else begin
            full  = ux - uy;
            r.res = full[15:0];
            r.co  = (ux >= uy);
            r.ov  = (x[15] != y[15]) && (r.res[15] != x[15]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Per-instance scoreboard step, called only from the monitor.
    task automatic monitorInst(input int i, input logic valid, input logic busy,
                               input logic done, input logic [3:0] sum,
                               input logic [15:0] res, input logic co,
                               input logic ov);
        int    bpc;
        int    ncyc;
        int    dig;
        bit    have;
        exp_t  e;
        string tag;
        logic [15:0] mask;
        bpc  = (i == 0) ? BPC_A : BPC_B;
        ncyc = W / bpc;
        tag  = (i == 0) ? "bpc1" : "bpc4";
        dig  = (i == 0) ? digIdx0 : digIdx1;
        have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have) e = (i == 0) ? q0[0] : q1[0];
        mask = 16'((1 << bpc) - 1);

        if (!valid) begin
            checkOutput({tag, " ser_sum zero when idle"}, 32'(sum), 32'd0);
        end else if (!have) begin
            checkOutput({tag, " ser_valid without request"}, 32'(valid), 32'd0);
        end else begin
            checkOutput({tag, " ser_sum digit"}, 32'(sum),
                        32'((e.res >> (dig * bpc)) & mask));
            dig = dig + 1;
        end

        if (done) begin
            if (!have) begin
                checkOutput({tag, " done without request"}, 32'(done), 32'd0);
            end else begin
                checkOutput({tag, " result"}, 32'(res), 32'(e.res));
                checkOutput({tag, " cout"}, 32'(co), 32'(e.co));
                checkOutput({tag, " ovf"}, 32'(ov), 32'(e.ov));
                checkOutput({tag, " done latency"}, 32'(cycle - e.startCycle), 32'(ncyc));
                checkOutput({tag, " ser_valid count"}, 32'(dig), 32'(ncyc));
                checkOutput({tag, " busy low in done"}, 32'(busy), 32'd0);
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                dig = 0;
            end
        end else if (have && (cycle - e.startCycle > ncyc + 4)) begin
            checkOutput({tag, " done timeout cycles"}, 32'(cycle - e.startCycle), 32'(ncyc));
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            dig = 0;
        end

        if (i == 0) digIdx0 = dig;
        else        digIdx1 = dig;
    endtask

    // Monitor: after a sampled reset everything must read zero and any
    // pending operation is dropped; otherwise run the scoreboard step.
    always @(negedge clk) begin
        if (!rstLast) begin
            checkOutput("bpc1 reset outputs",
                        32'({busy0, done0, valid0, 3'b000, sum0, result0, cout0, ovf0}), 32'd0);
            checkOutput("bpc4 reset outputs",
                        32'({busy1, done1, valid1, sum1, result1, cout1, ovf1}), 32'd0);
            q0.delete();
            q1.delete();
            digIdx0 = 0;
            digIdx1 = 0;
        end else begin
            monitorInst(0, valid0, busy0, done0, {3'b000, sum0}, result0, cout0, ovf0);
            monitorInst(1, valid1, busy1, done1, sum1, result1, cout1, ovf1);
        end
    end

    // Issue one accepted operation and push its expected outcome.
    task automatic issueStart(input int inst, input logic [15:0] x,
                              input logic [15:0] y, input logic s);
        @(posedge clk);
        #1;
        a   = x;
        b   = y;
        sub = s;
        if (inst == 0) start0 = 1'b1;
        else           start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (inst == 0) q0.push_back(model(x, y, s, cycle));
        else           q1.push_back(model(x, y, s, cycle));
    endtask

    task automatic applyStimulus(input int inst, input logic [15:0] x,
                                 input logic [15:0] y, input logic s);
        int ncyc;
        ncyc = (inst == 0) ? NCYC_A : NCYC_B;
        issueStart(inst, x, y, s);
        for (int n = 0; n < ncyc + 8; n++) begin
            if ((inst == 0 ? q0.size() : q1.size()) == 0) break;
            @(negedge clk);
        end
    endtask

    // Start pulses during RUN and during DONE must be ignored.
    task automatic ignoredStarts();
        issueStart(0, 16'h0001, 16'h0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a      = 16'hAAAA;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Abort an operation with reset asserted during the 5th RUN cycle.
    task automatic resetMidRun();
        issueStart(0, 16'h1234, 16'h4321, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (NCYC_A + 4) @(negedge clk);
    endtask

    function automatic logic [15:0] pickOperand();
        logic [15:0] edges [5];
        edges[0] = 16'h0000;
        edges[1] = 16'h0001;
        edges[2] = 16'h7FFF;
        edges[3] = 16'h8000;
        edges[4] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        checks  = 0;
        fails   = 0;
        digIdx0 = 0;
        digIdx1 = 0;
        reset   = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        sub     = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(0, 16'h1234, 16'h0FFF, 1'b0);
        applyStimulus(0, 16'h0005, 16'h0007, 1'b1);
        applyStimulus(0, 16'h0007, 16'h0005, 1'b1);
        applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0);
        applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0);
        applyStimulus(0, 16'h8000, 16'h0001, 1'b1);
        applyStimulus(1, 16'h1234, 16'h0FFF, 1'b0);
        applyStimulus(1, 16'h8000, 16'h0001, 1'b1);

        $display("[TB] ignored starts");
        ignoredStarts();
        applyStimulus(0, 16'hAAAA, 16'h0001, 1'b0);

        $display("[TB] reset during run");
        resetMidRun();
        applyStimulus(0, 16'h00FF, 16'h0001, 1'b0);

        $display("[TB] random operations");
        for (int k = 0; k < 30; k++) begin
            applyStimulus(0, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)));
            applyStimulus(1, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)));
        end

        repeat (NCYC_A + 10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
